// File: rtl/move_pulse_gen.sv
// Move button conditioner: synchroniser, debouncer and single-cycle move strobe
// with optional hold-to-repeat.
module move_pulse_gen #(
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic move,
  output logic pressed
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] DLY_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PER_LAST = TW'(REPEAT_PERIOD - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_RPT   = 2'd2;

  logic          sync1_q, sync2_q;
  logic          s;
  logic          pressed_q, pressed_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise;
  logic          move_q, move_d;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] t_q, t_d;

  assign s = sync2_q ^ BTN_ACTIVE_LOW;

  always_comb begin
    pressed_d = pressed_q;
    cnt_d     = '0;
    if (s != pressed_q) begin
      if (cnt_q == CNT_LAST) begin
        pressed_d = s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    rise = pressed_d & ~pressed_q;
  end

  // Release on this edge overrides any pulse the timers would issue.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    move_d  = 1'b0;
    if (!pressed_d) begin
      state_d = ST_IDLE;
      t_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            move_d  = 1'b1;
            t_d     = '0;
            state_d = REPEAT_EN ? ST_DELAY : ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (t_q == DLY_LAST) begin
            move_d  = 1'b1;
            t_d     = '0;
            state_d = ST_RPT;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        ST_RPT: begin
          if (t_q == PER_LAST) begin
            move_d = 1'b1;
            t_d    = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          t_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= BTN_ACTIVE_LOW;
      sync2_q   <= BTN_ACTIVE_LOW;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
      move_q    <= 1'b0;
      state_q   <= ST_IDLE;
      t_q       <= '0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
      move_q    <= move_d;
      state_q   <= state_d;
      t_q       <= t_d;
    end
  end

  assign move    = move_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_move_pulse_gen.sv
// Bench for move_pulse_gen: one-shot and auto-repeat instances share stimulus;
// expected pulse edges are queued up front and matched as move strobes appear.
module tb_move_pulse_gen;

  localparam int N = 4;
  localparam int D = 10;
  localparam int P = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_in = 1'b0;
  logic move0, pressed0;
  logic move1, pressed1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp0[$];
  int exp1[$];

  move_pulse_gen #(
    .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(N), .REPEAT_EN(1'b0),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) u0 (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .move(move0), .pressed(pressed0)
  );

  move_pulse_gen #(
    .BTN_ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(N), .REPEAT_EN(1'b1),
    .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) u1 (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .move(move1), .pressed(pressed1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: each observed strobe must match the next queued edge.
  always @(posedge clk) begin
    int e0, e1;
    #1;
    if (move0 === 1'b1) begin
      n_checks++;
      if (exp0.size() == 0) begin
        n_fail++;
        $display("FAIL move0_unexpected edge=%0d got=1 want=0", cyc);
      end else begin
        e0 = exp0.pop_front();
        if (e0 !== cyc) begin
          n_fail++;
          $display("FAIL move0_edge got=%0d want=%0d", cyc, e0);
        end
      end
    end
    if (move1 === 1'b1) begin
      n_checks++;
      if (exp1.size() == 0) begin
        n_fail++;
        $display("FAIL move1_unexpected edge=%0d got=1 want=0", cyc);
      end else begin
        e1 = exp1.pop_front();
        if (e1 !== cyc) begin
          n_fail++;
          $display("FAIL move1_edge got=%0d want=%0d", cyc, e1);
        end
      end
    end
  end

  task automatic do_press(input int hold, input int gap, input bit from_rst);
    int k, fall, t, c;
    bit acc, ep;
    @(negedge clk);
    if (from_rst) rst = 1'b0;
    else btn_in = 1'b0;
    k    = cyc + 1;
    acc  = (hold >= N);
    fall = k + hold + N + 1;
    if (acc) begin
      exp0.push_back(k + N + 1);
      exp1.push_back(k + N + 1);
      t = k + N + 1 + D;
      while (t < fall) begin
        exp1.push_back(t);
        t += P;
      end
    end
    for (int i = 0; i < hold + gap; i++) begin
      @(negedge clk);
      c  = cyc;
      ep = acc && (c >= k + N + 1) && (c < fall);
      n_checks += 2;
      if (pressed0 !== ep) begin
        n_fail++;
        $display("FAIL pressed0 edge=%0d got=%b want=%b", c, pressed0, ep);
      end
      if (pressed1 !== ep) begin
        n_fail++;
        $display("FAIL pressed1 edge=%0d got=%b want=%b", c, pressed1, ep);
      end
      if (c == k + hold - 1) btn_in = 1'b1;
    end
    n_checks += 2;
    if (exp0.size() !== 0) begin
      n_fail++;
      $display("FAIL move0_missing got=%0d want=0 pending", exp0.size());
      exp0.delete();
    end
    if (exp1.size() !== 0) begin
      n_fail++;
      $display("FAIL move1_missing got=%0d want=0 pending", exp1.size());
      exp1.delete();
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_checks += 4;
      if (pressed0 !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_pressed0 got=%b want=0", pressed0);
      end
      if (pressed1 !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_pressed1 got=%b want=0", pressed1);
      end
      if (move0 !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_move0 got=%b want=0", move0);
      end
      if (move1 !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_move1 got=%b want=0", move1);
      end
    end
    do_press(8, 10, 1'b1);
  endtask

  task automatic test_clean_press();
    do_press(20, 10, 1'b0);
  endtask

  task automatic test_glitch();
    do_press(3, 10, 1'b0);
    n_checks += 2;
    if (u0.cnt_q !== '0) begin
      n_fail++;
      $display("FAIL glitch_cnt0 got=%0d want=0", u0.cnt_q);
    end
    if (u1.cnt_q !== '0) begin
      n_fail++;
      $display("FAIL glitch_cnt1 got=%0d want=0", u1.cnt_q);
    end
    do_press(4, 10, 1'b0);
  endtask

  task automatic test_repeat();
    do_press(38, 10, 1'b0);
  endtask

  task automatic test_release_collision();
    do_press(35, 10, 1'b0);
    n_checks += 2;
    if (u1.state_q !== 2'd0) begin
      n_fail++;
      $display("FAIL coll_state got=%0d want=0", u1.state_q);
    end
    if (u1.t_q !== '0) begin
      n_fail++;
      $display("FAIL coll_timer got=%0d want=0", u1.t_q);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int k;
    @(negedge clk);
    btn_in = 1'b0;
    k = cyc + 1;
    exp0.push_back(k + N + 1);
    exp1.push_back(k + N + 1);
    exp1.push_back(k + N + 1 + D);
    exp1.push_back(k + N + 1 + D + P);
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 4;
    if (pressed1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pressed1 got=%b want=0", pressed1);
    end
    if (move1 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_move1 got=%b want=0", move1);
    end
    if (pressed0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pressed0 got=%b want=0", pressed0);
    end
    if (u1.state_q !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_state got=%0d want=0", u1.state_q);
    end
    do_press(8, 10, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_press(6, 7, 1'b0);
    do_press(6, 7, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_repeat();
    test_release_collision();
    test_reset_mid_repeat();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
